// File: rtl/mem_pkg.sv
// Shared constants for the memory responder: FSM state encoding, read/write
// select values and default bus widths.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_DONE   = 2'b10
  } state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous word RAM with registered read. Callers gate we/re
// with their own range check; rd_clr loads zero into the read register instead.
module mem_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic              rd_clr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  idx;

  assign idx = addr[IDX_W-1:0];

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (rd_clr) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts mem_EN/mem_RW requests, waits LATENCY edges,
// performs the access, then holds MFC until the initiator drops mem_EN.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_EN,
  input  logic              mem_RW,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              MFC,
  output logic              addr_err,
  output logic              busy,
  output state_t            state_dbg
);

  // Handshake: mem_EN is a level request. MFC rises once the access is done
  // and stays high until mem_EN is seen low, which also returns us to idle.

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       in_range;
  logic       complete;
  logic       ram_we;
  logic       ram_re;
  logic       ram_clr;

  assign in_range = 32'(addr_in) < 32'(DEPTH);
  assign complete = (state == ST_ACCESS) && mem_EN && (cnt == 4'd0);
  assign ram_we   = complete && (mem_RW == RW_WRITE) && in_range;
  assign ram_re   = complete && (mem_RW == RW_READ) && in_range;
  assign ram_clr  = complete && (mem_RW == RW_READ) && !in_range;

  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      cnt      <= 4'd0;
      MFC      <= 1'b0;
      addr_err <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (mem_EN) begin
            state <= ST_ACCESS;
            cnt   <= CNT_LOAD;
            busy  <= 1'b1;
          end
        end
        ST_ACCESS: begin
          if (!mem_EN) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state    <= ST_DONE;
            MFC      <= 1'b1;
            addr_err <= !in_range;
          end
        end
        ST_DONE: begin
          if (!mem_EN) begin
            state    <= ST_IDLE;
            MFC      <= 1'b0;
            addr_err <= 1'b0;
            busy     <= 1'b0;
          end
        end
        default: begin
          state    <= ST_IDLE;
          MFC      <= 1'b0;
          addr_err <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  mem_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .rst_n (rst),
    .we    (ram_we),
    .re    (ram_re),
    .rd_clr(ram_clr),
    .addr  (addr_in),
    .wdata (data_in),
    .rdata (data_out)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed handshake scenarios plus random traffic,
// scored against a word-array model of the memory.
module tb_mem_responder;
  import mem_pkg::*;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 16;
  localparam int DEPTH   = 128;
  localparam int LATENCY = 3;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic              mem_EN = 1'b0;
  logic              mem_RW = 1'b0;
  logic [ADDR_W-1:0] addr_in = '0;
  logic [DATA_W-1:0] data_in = '0;
  logic [DATA_W-1:0] data_out;
  logic              MFC;
  logic              addr_err;
  logic              busy;
  state_t            state_dbg;

  mem_responder #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .LATENCY(LATENCY)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mem_EN   (mem_EN),
    .mem_RW   (mem_RW),
    .addr_in  (addr_in),
    .data_in  (data_in),
    .data_out (data_out),
    .MFC      (MFC),
    .addr_err (addr_err),
    .busy     (busy),
    .state_dbg(state_dbg)
  );

  int total = 0;
  int bad   = 0;

  // reference model
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic [DATA_W-1:0] last_rd = '0;
  logic [DATA_W:0]   exp_q [$];   // {addr_err, data_out}

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // scoreboard monitor: compare on every rising MFC
  logic mfc_q = 1'b0;
  always @(negedge clk) begin
    logic [DATA_W:0] e;
    if (MFC && !mfc_q) begin
      if (exp_q.size() == 0) begin
        check("unexpected_mfc", 32'(MFC), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("data_out", 32'(data_out), 32'(e[DATA_W-1:0]));
        check("addr_err", 32'(addr_err), 32'(e[DATA_W]));
      end
    end
    mfc_q = MFC;
  end

  // Expected result of one completed access under the memory rules.
  task automatic model_access(input bit rw, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bit oob;
    oob = (int'(a) >= DEPTH);
    if (rw) last_rd = oob ? '0 : ref_mem[int'(a)];
    else if (!oob) ref_mem[int'(a)] = d;
    exp_q.push_back({oob, last_rd});
  endtask

  // driver: one request; abort_after>0 drops mem_EN that many cycles after accept
  task automatic do_access(input bit rw, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                           input int abort_after, input bit fetch_sw, input int hold);
    int n;
    @(posedge clk); #1;
    mem_EN  = 1'b1;
    mem_RW  = fetch_sw ? RW_WRITE : rw;
    addr_in = a;
    data_in = d;
    @(posedge clk); #1;
    check("busy_after_accept", 32'(busy), 32'd1);
    check("state_access", 32'(state_dbg), 32'(ST_ACCESS));
    if (fetch_sw) mem_RW = RW_READ;
    if (abort_after > 0) begin
      repeat (abort_after - 1) begin
        @(posedge clk); #1;
      end
      mem_EN = 1'b0;
      @(posedge clk); #1;
      check("abort_idle", 32'(state_dbg), 32'(ST_IDLE));
      check("abort_mfc", 32'(MFC), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      return;
    end
    model_access(fetch_sw ? 1'b1 : rw, a, d);
    n = 0;
    while (n < 20) begin
      @(posedge clk); #1;
      n++;
      if (MFC) break;
      check("busy_in_access", 32'(busy), 32'd1);
    end
    check("latency", 32'(n), 32'(LATENCY));
    repeat (hold) begin
      @(posedge clk); #1;
      check("hold_mfc", 32'(MFC), 32'd1);
      check("hold_busy", 32'(busy), 32'd1);
    end
    mem_EN = 1'b0;
    @(posedge clk); #1;
    check("release_mfc", 32'(MFC), 32'd0);
    check("release_err", 32'(addr_err), 32'd0);
    check("release_busy", 32'(busy), 32'd0);
    check("release_idle", 32'(state_dbg), 32'(ST_IDLE));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    logic [DATA_W-1:0] old;
    repeat (3) @(negedge clk);
    check("reset_mfc", 32'(MFC), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_data", 32'(data_out), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("reset_idle", 32'(state_dbg), 32'(ST_IDLE));
    check("reset_err", 32'(addr_err), 32'd0);

    // fill every implemented word so reads are always defined
    for (int i = 0; i < DEPTH; i++)
      do_access(RW_WRITE, ADDR_W'(i), DATA_W'($urandom), 0, 1'b0, 0);

    // write then read, fetch-style RW switch
    do_access(RW_WRITE, 8'h10, 16'hBEEF, 0, 1'b0, 0);
    do_access(RW_READ,  8'h10, 16'h0000, 0, 1'b0, 0);
    do_access(RW_WRITE, 8'h10, 16'h1111, 0, 1'b1, 0);
    do_access(RW_READ,  8'h10, 16'h0000, 0, 1'b0, 0);

    // abort leaves the word unchanged
    do_access(RW_WRITE, 8'h20, 16'h1234, 1, 1'b0, 0);
    do_access(RW_READ,  8'h20, 16'h0000, 0, 1'b0, 0);

    // out of range and aliasing
    do_access(RW_READ,  8'hC0, 16'h0000, 0, 1'b0, 0);
    do_access(RW_WRITE, 8'hC0, 16'hAAAA, 0, 1'b0, 0);
    do_access(RW_READ,  8'h40, 16'h0000, 0, 1'b0, 0);

    // long hold, then minimum spacing
    do_access(RW_READ,  8'h10, 16'h0000, 0, 1'b0, 10);
    do_access(RW_READ,  8'h7F, 16'h0000, 0, 1'b0, 0);

    // reset two cycles into a write
    do_access(RW_READ, 8'h10, 16'h0000, 0, 1'b0, 0);
    old = ref_mem[8'h30];
    @(posedge clk); #1;
    mem_EN = 1'b1; mem_RW = RW_WRITE; addr_in = 8'h30; data_in = ~old;
    repeat (3) begin
      @(posedge clk); #1;
    end
    #2 rst = 1'b0;
    #1;
    check("rst_mid_mfc", 32'(MFC), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_data", 32'(data_out), 32'd0);
    check("rst_mid_idle", 32'(state_dbg), 32'(ST_IDLE));
    mem_EN = 1'b0;
    last_rd = '0;
    @(negedge clk);
    rst = 1'b1;
    do_access(RW_READ, 8'h30, 16'h0000, 0, 1'b0, 0);

    // random traffic
    for (int k = 0; k < 60; k++) begin
      int ab;
      ab = ($urandom_range(0, 9) == 0) ? $urandom_range(1, LATENCY - 1) : 0;
      do_access(1'($urandom), ADDR_W'($urandom_range(0, 255)), DATA_W'($urandom),
                ab, ($urandom_range(0, 4) == 0), $urandom_range(0, 3));
    end

    repeat (4) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
